// File: rtl/rect_fill_ctrl_pkg.sv
// Shared definitions for the rectangle-fill controller: screen geometry,
// FSM encodings, colour codes, the latched rectangle and a constant shift-add multiply.
package rect_fill_ctrl_pkg;

  localparam int unsigned H_CELLS_DEF = 40;
  localparam int unsigned V_CELLS_DEF = 30;
  localparam int unsigned ADDR_W_DEF  = 11;
  localparam int unsigned COLOR_W_DEF = 3;

  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_SETUP = 2'd1;
  localparam logic [1:0] ST_FILL  = 2'd2;
  localparam logic [1:0] ST_DONE  = 2'd3;

  localparam logic [2:0] COLOR_BLACK   = 3'd0;
  localparam logic [2:0] COLOR_BLUE    = 3'd1;
  localparam logic [2:0] COLOR_GREEN   = 3'd2;
  localparam logic [2:0] COLOR_CYAN    = 3'd3;
  localparam logic [2:0] COLOR_RED     = 3'd4;
  localparam logic [2:0] COLOR_MAGENTA = 3'd5;
  localparam logic [2:0] COLOR_YELLOW  = 3'd6;
  localparam logic [2:0] COLOR_WHITE   = 3'd7;

  typedef struct packed {
    logic [5:0] x0;
    logic [5:0] x1;
    logic [4:0] y0;
    logic [4:0] y1;
  } rect_t;

  // Multiply by a constant as a sum of shifted copies; with k fixed at
  // elaboration this folds to adders only (40 = 32 + 8).
  function automatic logic [15:0] const_mul(input logic [15:0] v, input int unsigned k);
    logic [15:0] acc;
    acc = '0;
    for (int b = 0; b < 16; b++) begin
      if (k[b]) begin
        acc = acc + (v << b);
      end
    end
    return acc;
  endfunction

endpackage

// File: rtl/rect_scan_counter.sv
// Row-major scan of a rectangle: x/y counters, row-base accumulator,
// hold (no step) support and a last-pixel flag.
module rect_scan_counter
  import rect_fill_ctrl_pkg::*;
#(
  parameter int unsigned ADDR_W  = ADDR_W_DEF,
  parameter int unsigned H_CELLS = H_CELLS_DEF
) (
  input  logic              clk_i,
  input  logic              rst_ni,
  input  logic              load_i,
  input  logic              step_i,
  input  logic [5:0]        x0_i,
  input  logic [5:0]        x1_i,
  input  logic [4:0]        y0_i,
  input  logic [4:0]        y1_i,
  input  logic [ADDR_W-1:0] base_i,
  output logic [ADDR_W-1:0] addr_o,
  output logic              last_o
);

  localparam logic [ADDR_W-1:0] ROW_STEP = ADDR_W'(H_CELLS);

  logic [5:0]        x_q, x_d;
  logic [4:0]        y_q, y_d;
  logic [ADDR_W-1:0] row_base_q, row_base_d;

  always_comb begin
    x_d        = x_q;
    y_d        = y_q;
    row_base_d = row_base_q;
    if (load_i) begin
      x_d        = x0_i;
      y_d        = y0_i;
      row_base_d = base_i;
    end else if (step_i) begin
      if (x_q == x1_i) begin
        x_d        = x0_i;
        y_d        = y_q + 5'd1;
        row_base_d = row_base_q + ROW_STEP;
      end else begin
        x_d = x_q + 6'd1;
      end
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      x_q        <= '0;
      y_q        <= '0;
      row_base_q <= '0;
    end else begin
      x_q        <= x_d;
      y_q        <= y_d;
      row_base_q <= row_base_d;
    end
  end

  assign addr_o = row_base_q + ADDR_W'(x_q);
  assign last_o = (x_q == x1_i) && (y_q == y1_i);

endmodule

// File: rtl/rect_fill_ctrl.sv
// Rectangle-fill controller sharing the single video-RAM write port with
// CPU single-cell writes; the CPU always wins and the fill simply stalls.
module rect_fill_ctrl
  import rect_fill_ctrl_pkg::*;
#(
  parameter int unsigned H_CELLS = H_CELLS_DEF,
  parameter int unsigned V_CELLS = V_CELLS_DEF,
  parameter int unsigned ADDR_W  = ADDR_W_DEF,
  parameter int unsigned COLOR_W = COLOR_W_DEF
) (
  input  logic               Clock,
  input  logic               Reset,
  input  logic               iCpuWrEn,
  input  logic [ADDR_W-1:0]  iCpuAddr,
  input  logic [COLOR_W-1:0] iCpuColor,
  input  logic               iFillStart,
  input  logic [5:0]         iX0,
  input  logic [5:0]         iX1,
  input  logic [4:0]         iY0,
  input  logic [4:0]         iY1,
  input  logic [COLOR_W-1:0] iFillColor,
  output logic               oBusy,
  output logic               oDone,
  output logic               oError,
  output logic               oVramWe,
  output logic [ADDR_W-1:0]  oVramAddr,
  output logic [COLOR_W-1:0] oVramData
);

  localparam logic [5:0] X_MAX = 6'(H_CELLS - 1);
  localparam logic [4:0] Y_MAX = 5'(V_CELLS - 1);

  logic [1:0]         state_q, state_d;
  rect_t              req_q, req_d;
  logic [COLOR_W-1:0] color_q, color_d;
  logic               error_q, error_d;
  logic               vram_we_q, vram_we_d;
  logic [ADDR_W-1:0]  vram_addr_q, vram_addr_d;
  logic [COLOR_W-1:0] vram_data_q, vram_data_d;

  logic [5:0]        x1_clamp;
  logic [4:0]        y1_clamp;
  logic              reject;
  logic [ADDR_W-1:0] base_init;
  logic              scan_load;
  logic              scan_step;
  logic              fill_issue;
  logic [ADDR_W-1:0] scan_addr;
  logic              scan_last;

  assign x1_clamp  = (req_q.x1 > X_MAX) ? X_MAX : req_q.x1;
  assign y1_clamp  = (req_q.y1 > Y_MAX) ? Y_MAX : req_q.y1;
  assign reject    = (req_q.x0 > X_MAX) || (req_q.y0 > Y_MAX) ||
                     (req_q.x0 > x1_clamp) || (req_q.y0 > y1_clamp);
  assign base_init = ADDR_W'(const_mul(16'(req_q.y0), H_CELLS));

  // A CPU write steals the port for one cycle; the scan just holds.
  assign fill_issue = (state_q == ST_FILL) && !iCpuWrEn;

  always_comb begin
    state_d   = state_q;
    req_d     = req_q;
    color_d   = color_q;
    error_d   = error_q;
    scan_load = 1'b0;
    scan_step = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (iFillStart) begin
          req_d   = '{x0: iX0, x1: iX1, y0: iY0, y1: iY1};
          color_d = iFillColor;
          error_d = 1'b0;
          state_d = ST_SETUP;
        end
      end
      ST_SETUP: begin
        if (reject) begin
          error_d = 1'b1;
          state_d = ST_DONE;
        end else begin
          req_d.x1  = x1_clamp;
          req_d.y1  = y1_clamp;
          scan_load = 1'b1;
          state_d   = ST_FILL;
        end
      end
      ST_FILL: begin
        if (fill_issue) begin
          scan_step = 1'b1;
          if (scan_last) begin
            state_d = ST_DONE;
          end
        end
      end
      ST_DONE: begin
        state_d = ST_IDLE;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  rect_scan_counter #(
    .ADDR_W  (ADDR_W),
    .H_CELLS (H_CELLS)
  ) u_scan (
    .clk_i  (Clock),
    .rst_ni (Reset),
    .load_i (scan_load),
    .step_i (scan_step),
    .x0_i   (req_q.x0),
    .x1_i   (req_q.x1),
    .y0_i   (req_q.y0),
    .y1_i   (req_q.y1),
    .base_i (base_init),
    .addr_o (scan_addr),
    .last_o (scan_last)
  );

  always_comb begin
    vram_we_d   = iCpuWrEn | fill_issue;
    vram_addr_d = vram_addr_q;
    vram_data_d = vram_data_q;
    if (iCpuWrEn) begin
      vram_addr_d = iCpuAddr;
      vram_data_d = iCpuColor;
    end else if (fill_issue) begin
      vram_addr_d = scan_addr;
      vram_data_d = color_q;
    end
  end

  always_ff @(posedge Clock or negedge Reset) begin
    if (!Reset) begin
      state_q     <= ST_IDLE;
      req_q       <= '0;
      color_q     <= '0;
      error_q     <= 1'b0;
      vram_we_q   <= 1'b0;
      vram_addr_q <= '0;
      vram_data_q <= '0;
    end else begin
      state_q     <= state_d;
      req_q       <= req_d;
      color_q     <= color_d;
      error_q     <= error_d;
      vram_we_q   <= vram_we_d;
      vram_addr_q <= vram_addr_d;
      vram_data_q <= vram_data_d;
    end
  end

  assign oBusy     = (state_q != ST_IDLE);
  assign oDone     = (state_q == ST_DONE);
  assign oError    = error_q;
  assign oVramWe   = vram_we_q;
  assign oVramAddr = vram_addr_q;
  assign oVramData = vram_data_q;

endmodule

// File: tb/tb_rect_fill_ctrl.sv
// Scoreboard bench for rect_fill_ctrl: stimulus queues expected writes and
// completion events; a negedge monitor pops and compares them.
module tb_rect_fill_ctrl;
  import rect_fill_ctrl_pkg::*;

  logic        Clock;
  logic        Reset;
  logic        iCpuWrEn;
  logic [10:0] iCpuAddr;
  logic [2:0]  iCpuColor;
  logic        iFillStart;
  logic [5:0]  iX0, iX1;
  logic [4:0]  iY0, iY1;
  logic [2:0]  iFillColor;
  logic        oBusy, oDone, oError, oVramWe;
  logic [10:0] oVramAddr;
  logic [2:0]  oVramData;

  rect_fill_ctrl dut (
    .Clock      (Clock),
    .Reset      (Reset),
    .iCpuWrEn   (iCpuWrEn),
    .iCpuAddr   (iCpuAddr),
    .iCpuColor  (iCpuColor),
    .iFillStart (iFillStart),
    .iX0        (iX0),
    .iX1        (iX1),
    .iY0        (iY0),
    .iY1        (iY1),
    .iFillColor (iFillColor),
    .oBusy      (oBusy),
    .oDone      (oDone),
    .oError     (oError),
    .oVramWe    (oVramWe),
    .oVramAddr  (oVramAddr),
    .oVramData  (oVramData)
  );

  typedef struct {
    int addr;
    int data;
    int cyc;
  } wr_t;

  typedef struct {
    int cyc;
    int err;
  } dn_t;

  wr_t wr_q[$];
  dn_t dn_q[$];
  int  checks = 0;
  int  errors = 0;
  int  cyc = 0;
  int  start_cyc = 0;

  initial Clock = 1'b0;
  always #5 Clock = ~Clock;

  always @(posedge Clock) cyc <= cyc + 1;

  // Monitor: cycle 1 is the clock period right after the start-sampling edge.
  always @(negedge Clock) begin
    int  rel;
    wr_t w;
    dn_t d;
    rel = cyc - start_cyc + 1;
    if (Reset) begin
      if (oVramWe) begin
        checks++;
        if (wr_q.size() == 0) begin
          errors++;
          $display("FAIL wr_unexpected: got addr=%0d data=%0d cyc=%0d, required no write", oVramAddr, oVramData, rel);
        end else begin
          w = wr_q.pop_front();
          if (int'(oVramAddr) != w.addr || int'(oVramData) != w.data || (w.cyc >= 0 && rel != w.cyc)) begin
            errors++;
            $display("FAIL wr: got addr=%0d data=%0d cyc=%0d, required addr=%0d data=%0d cyc=%0d",
                     oVramAddr, oVramData, rel, w.addr, w.data, w.cyc);
          end else begin
            $display("WR addr=%0d data=%0d cyc=%0d", oVramAddr, oVramData, rel);
          end
        end
      end
      if (oDone) begin
        checks++;
        if (dn_q.size() == 0) begin
          errors++;
          $display("FAIL done_unexpected: got done at cyc=%0d err=%0d, required none", rel, oError);
        end else begin
          d = dn_q.pop_front();
          if (rel != d.cyc || int'(oError) != d.err) begin
            errors++;
            $display("FAIL done: got cyc=%0d err=%0d, required cyc=%0d err=%0d", rel, oError, d.cyc, d.err);
          end else begin
            $display("DONE cyc=%0d err=%0d", rel, oError);
          end
        end
      end
    end
  end

  task automatic chk(input string name, input int got, input int exp);
    checks++;
    if (got != exp) begin
      errors++;
      $display("FAIL %s: got %0d, required %0d", name, got, exp);
    end
  endtask

  task automatic push_wr(input int addr, input int data, input int c);
    wr_t w;
    w.addr = addr;
    w.data = data;
    w.cyc  = c;
    wr_q.push_back(w);
  endtask

  task automatic push_done(input int c, input int err);
    dn_t d;
    d.cyc = c;
    d.err = err;
    dn_q.push_back(d);
  endtask

  // Expected writes of an uninterrupted fill, first one visible in cycle 3.
  task automatic push_rect(input int x0, input int x1, input int y0, input int y1,
                           input int col, input int max_n);
    int n;
    n = 0;
    for (int y = y0; y <= y1; y++) begin
      for (int x = x0; x <= x1; x++) begin
        if (n < max_n) push_wr(y * 40 + x, col, 3 + n);
        n++;
      end
    end
  endtask

  task automatic start_fill(input int x0, input int x1, input int y0, input int y1, input int col);
    @(negedge Clock);
    iX0        = 6'(x0);
    iX1        = 6'(x1);
    iY0        = 5'(y0);
    iY1        = 5'(y1);
    iFillColor = 3'(col);
    iFillStart = 1'b1;
    @(posedge Clock);
    #1;
    start_cyc  = cyc;
    iFillStart = 1'b0;
  endtask

  task automatic wait_idle(input int budget);
    bit idle;
    idle = 1'b0;
    for (int i = 0; i < budget && !idle; i++) begin
      @(negedge Clock);
      if (!oBusy) idle = 1'b1;
    end
    if (!idle) chk("idle_timeout", 0, 1);
    repeat (2) @(negedge Clock);
  endtask

  task automatic chk_outputs_zero(input string tag);
    chk({tag, "_busy"}, int'(oBusy), 0);
    chk({tag, "_done"}, int'(oDone), 0);
    chk({tag, "_error"}, int'(oError), 0);
    chk({tag, "_we"}, int'(oVramWe), 0);
    chk({tag, "_addr"}, int'(oVramAddr), 0);
    chk({tag, "_data"}, int'(oVramData), 0);
  endtask

  initial begin
    Reset      = 1'b0;
    iCpuWrEn   = 1'b0;
    iCpuAddr   = '0;
    iCpuColor  = '0;
    iFillStart = 1'b0;
    iX0 = '0; iX1 = '0; iY0 = '0; iY1 = '0;
    iFillColor = '0;
    repeat (3) @(negedge Clock);
    chk_outputs_zero("reset");
    #1 Reset = 1'b1;
    repeat (2) @(negedge Clock);

    // CPU write while idle passes straight through
    push_wr(1000, COLOR_GREEN, -1);
    iCpuWrEn = 1'b1; iCpuAddr = 11'd1000; iCpuColor = COLOR_GREEN;
    @(negedge Clock);
    iCpuWrEn = 1'b0;
    repeat (3) @(negedge Clock);

    // Two-pixel fill: 153, 154 in cycles 3, 4; done in 4, idle in 5
    push_rect(33, 34, 3, 3, COLOR_WHITE, 1000);
    push_done(4, 0);
    start_fill(33, 34, 3, 3, COLOR_WHITE);
    @(negedge Clock);
    chk("busy_c1", int'(oBusy), 1);
    repeat (4) @(negedge Clock);
    chk("busy_c5", int'(oBusy), 0);
    wait_idle(20);

    // Sky: x1 clamps to 39, 760 writes, done in cycle 762
    push_rect(0, 39, 0, 18, COLOR_CYAN, 1000);
    push_done(762, 0);
    start_fill(0, 40, 0, 18, COLOR_CYAN);
    wait_idle(900);

    // CPU write in cycle 2 stalls the fill by one cycle
    push_wr(5, COLOR_RED, 3);
    push_wr(720, COLOR_BLUE, 4);
    push_wr(721, COLOR_BLUE, 5);
    push_done(5, 0);
    start_fill(0, 1, 18, 18, COLOR_BLUE);
    @(negedge Clock);
    @(negedge Clock);
    iCpuWrEn = 1'b1; iCpuAddr = 11'd5; iCpuColor = COLOR_RED;
    @(negedge Clock);
    iCpuWrEn = 1'b0;
    wait_idle(20);

    // Rejections: x0 > x1, x0 off-screen, y0 off-screen
    push_done(2, 1);
    start_fill(5, 4, 0, 0, COLOR_RED);
    wait_idle(20);
    repeat (3) @(negedge Clock);
    chk("error_sticky", int'(oError), 1);
    push_done(2, 1);
    start_fill(40, 45, 0, 0, COLOR_RED);
    wait_idle(20);
    push_done(2, 1);
    start_fill(0, 3, 30, 31, COLOR_RED);
    wait_idle(20);
    chk("error_sticky2", int'(oError), 1);

    // Bottom-right corner with both bounds clamped; accepted start clears error
    push_wr(1158, COLOR_MAGENTA, 3);
    push_wr(1159, COLOR_MAGENTA, 4);
    push_wr(1198, COLOR_MAGENTA, 5);
    push_wr(1199, COLOR_MAGENTA, 6);
    push_done(6, 0);
    start_fill(38, 50, 28, 31, COLOR_MAGENTA);
    @(negedge Clock);
    chk("error_clear", int'(oError), 0);
    wait_idle(20);

    // Reset after the 10th pixel of the sky fill
    push_rect(0, 39, 0, 18, COLOR_YELLOW, 10);
    start_fill(0, 40, 0, 18, COLOR_YELLOW);
    @(negedge Clock);
    repeat (11) @(negedge Clock);
    #1 Reset = 1'b0;
    #1 chk_outputs_zero("abort");
    chk("abort_pending", wr_q.size(), 0);
    repeat (3) @(negedge Clock);
    #1 Reset = 1'b1;
    push_wr(0, COLOR_GREEN, 3);
    push_done(3, 0);
    start_fill(0, 0, 0, 0, COLOR_GREEN);
    wait_idle(20);

    // Start pulse in cycle 5 of an active fill is ignored
    push_rect(2, 6, 1, 2, COLOR_YELLOW, 1000);
    push_done(12, 0);
    start_fill(2, 6, 1, 2, COLOR_YELLOW);
    @(negedge Clock);
    repeat (4) @(negedge Clock);
    iX0 = 6'd0; iX1 = 6'd0; iY0 = 5'd0; iY1 = 5'd0; iFillColor = COLOR_RED;
    iFillStart = 1'b1;
    @(negedge Clock);
    iFillStart = 1'b0;
    wait_idle(40);
    repeat (5) @(negedge Clock);
    chk("ignored_start_busy", int'(oBusy), 0);

    chk("wr_queue_empty", wr_q.size(), 0);
    chk("done_queue_empty", dn_q.size(), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL global_timeout: got no finish, required finish");
    $fatal(1, "timeout");
  end

endmodule

// File: doc/rect_fill_ctrl.md
# rect_fill_ctrl

Hardware rectangle-fill controller and write arbiter for the 40x30 cell video RAM. The CPU gives it inclusive corner coordinates and a colour. It then issues one video-RAM write per clock, so drawing no longer loops a subroutine per pixel. The block shares the single video-RAM write port between CPU `VGA` single-cell writes, which always have priority, and its own fill sequence.

## Interface
- `H_CELLS`, 40, cells per row
- `V_CELLS`, 30, rows
- `ADDR_W`, 11, video-RAM address width (1200 cells)
- `COLOR_W`, 3, colour code width
- `Clock`  in  1  system clock, rising edge
- `Reset`  in  1  asynchronous, active-low reset
- `iCpuWrEn`  in  1  CPU single-cell write request
- `iCpuAddr`  in  `ADDR_W`  CPU write address
- `iCpuColor`  in  `COLOR_W`  CPU write data
- `iFillStart`  in  1  fill request pulse; sampled only in IDLE
- `iX0`, `iX1`  in  6  inclusive column bounds
- `iY0`, `iY1`  in  5  inclusive row bounds
- `iFillColor`  in  `COLOR_W`  fill colour
- `oBusy`  out  1  fill in progress (state != IDLE)
- `oDone`  out  1  one-cycle completion pulse
- `oError`  out  1  last fill rejected; sticky
- `oVramWe`  out  1  registered write enable
- `oVramAddr`  out  `ADDR_W`  registered write address
- `oVramData`  out  `COLOR_W`  registered write data

## Operation
- FSM states: IDLE, SETUP, FILL, DONE.
- **IDLE**
  - On `iFillStart`, latch the bounds and colour, clear `oError`, go to SETUP.
  - `iFillStart` is ignored in every other state.
- **SETUP**
  - Clamp: `x1 = min(iX1, H_CELLS-1)`, `y1 = min(iY1, V_CELLS-1)`.
  - Reject the fill if `x0 >= H_CELLS`, `y0 >= V_CELLS`, `x0 > x1` or `y0 > y1`. On reject, set `oError` and go to DONE with no writes.
  - Otherwise `rowBase = y0*H_CELLS`, computed with a shift-add (40 = 32+8), no multiplier. Then `x = x0`, `y = y0`; go to FILL.
- **FILL**
  - Each cycle with `iCpuWrEn` low: issue a write to `rowBase + x`.
  - Advance `x`. At `x == x1`: set `x = x0`, `y++`, `rowBase += H_CELLS`.
  - After the pixel at `(x1, y1)`, go to DONE.
  - Order is row-major, left to right, top to bottom.
- **Arbitration**
  - When `iCpuWrEn` is high, the CPU write takes the port in any state.
  - During FILL, the fill counters hold for that cycle and nothing is dropped.
  - CPU writes in IDLE and SETUP pass through unchanged.
- **DONE**: `oDone` is high for one cycle, then the FSM returns to IDLE.
- **Arithmetic**
  - All addresses are unsigned, `ADDR_W` bits.
  - The maximum address, 1199, cannot overflow.
  - Coordinate compares are unsigned.

## Timing
- Cycle numbering: cycle 0 is the edge that samples `iFillStart`. N is the pixel count.
- With no CPU traffic:
  - SETUP is cycle 1.
  - Pixel issues occur in cycles 2..N+1.
  - Each write is visible on `oVramWe`/`oVramAddr`/`oVramData` one cycle after issue, i.e. cycles 3..N+2.
  - DONE and `oDone` fall in cycle N+2, coincident with the last write.
  - `oBusy` is high in cycles 1..N+2.
- Each CPU write during FILL delays completion by exactly one cycle.
- CPU write latency is one cycle from request to bus.
- On rejection, `oDone` and `oError` are both high in cycle 2, with no writes.
- `oError` stays high until the next accepted start.
- Reset (asynchronous, low):
  - All outputs go to 0 immediately: `oBusy`, `oDone`, `oError`, `oVramWe`, `oVramAddr`, `oVramData`.
  - FSM goes to IDLE and counters clear.
  - A fill in progress is abandoned and no further writes are issued.
- A start arriving in the DONE cycle is ignored; software must poll `oBusy`.

## Structure
- Add to the shared definitions header:
  - `H_CELLS` and `V_CELLS` defaults.
  - FSM state encodings.
  - Colour codes `COLOR_*`.
- Sub-module `rect_scan_counter`: x/y counters, `rowBase` accumulator, hold input and last-pixel flag.
- Clamp, reject logic, FSM and the output register stay in the top level.

## Test plan
- Fill (33,3)-(34,3), colour 3'b111:
  - Writes to addr 153 then 154 on consecutive cycles (cycles 3, 4).
  - `oDone` in cycle 4; `oBusy` low in cycle 5.
- Fill (0,0)-(40,18), the sky case:
  - `x1` clamps to 39.
  - 760 writes to addresses 0..759 in order.
  - `oDone` in cycle 762; `oError` = 0.
- Fill (0,18)-(1,18), with `iCpuWrEn` addr 5 held high in cycle 2:
  - Bus sequence: 5, 720, 721.
  - `oDone` in cycle 5 instead of cycle 4.
- Fill with `iX0`=5, `iX1`=4:
  - No `oVramWe`.
  - `oDone` and `oError` high in cycle 2.
  - `oError` stays high until the next valid start.
- Assert `Reset` after the 10th pixel of the 760-pixel fill:
  - All outputs 0 immediately, with no further writes.
  - After release, fill (0,0)-(0,0) writes addr 0 once.
- Pulse `iFillStart` at cycle 5 of an active fill:
  - Ignored; only the original rectangle's addresses are written.
